// File: rtl/load_store_unit.sv
// Load/store unit: valid/ready request port, in-order store buffer drained in idle
// cycles, youngest-match load forwarding and a registered one-cycle response.
module load_store_unit #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int MEM_DEPTH = 64,
  parameter int SB_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_abus,
  output logic [DATA_W-1:0] mem_dout,
  input  logic [DATA_W-1:0] mem_din,
  output logic              sb_empty
);

  localparam int PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]  MEM_LIM = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_DEPTH);

  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              rsp_valid_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;

  logic              accept, in_range, push, drain, load_rd, mem_rd;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic [PTR_W-1:0]  idx;

  assign req_ready = (count_q != SB_FULL);
  assign accept    = req_valid & req_ready & ~rst;
  assign in_range  = ({1'b0, req_addr} < MEM_LIM);
  assign push      = accept & req_we & in_range;
  assign load_rd   = accept & ~req_we & in_range;
  assign drain     = ~rst & ~accept & (count_q != '0);
  assign sb_empty  = (count_q == '0);

  // Scan oldest to youngest so the last match left standing is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (sb_addr_q[idx] == req_addr)) begin
        hit      = 1'b1;
        hit_data = sb_data_q[idx];
      end
    end
  end

  assign mem_rd = load_rd & ~hit;

  always_comb begin
    mem_read  = mem_rd;
    mem_write = drain;
    mem_abus  = '0;
    mem_dout  = '0;
    if (mem_rd) begin
      mem_abus = req_addr;
    end else if (drain) begin
      mem_abus = sb_addr_q[head_q];
      mem_dout = sb_data_q[head_q];
    end
  end

  always_comb begin
    rsp_rdata_d = '0;
    if (load_rd) rsp_rdata_d = hit ? hit_data : mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (push) begin
        sb_addr_q[tail_q] <= req_addr;
        sb_data_q[tail_q] <= req_wdata;
        tail_q            <= tail_q + PTR_W'(1);
        count_q           <= count_q + CNT_W'(1);
      end else if (drain) begin
        head_q  <= head_q + PTR_W'(1);
        count_q <= count_q - CNT_W'(1);
      end
      rsp_valid_q <= accept;
      rsp_err_q   <= accept & ~in_range;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
